// File: rtl/hq2x_scanout.sv
// Hq2x VGA scan-out: 640x480 raster timing, centred 512-wide image fetch, BGR555 to RGB888 expansion.
// Optional HQ2X_SCANLINE_EN adds a scanlines input that halves the intensity of odd output lines.
module hq2x_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int IMG_X0   = 64,
   parameter int IMG_W    = 512,
   parameter bit SYNC_NEG = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] outpixel,
`ifdef HQ2X_SCANLINE_EN
   input  logic        scanlines,
`endif
   output logic [9:0]  read_x,
   output logic        reset_line,
   output logic        reset_frame,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] IMG_LO   = 11'(IMG_X0);
   localparam logic [10:0] IMG_HI   = 11'(IMG_X0 + IMG_W);

   function automatic logic [7:0] expand5(input logic [4:0] c);
      expand5 = {c, c[4:2]};
   endfunction

   logic [9:0]  hcount_r, vcount_r;
   logic        active_s, hs_s, vs_s, in_img_s, line_start_s, fetch_s;
   logic [10:0] hpos_s, look_s;
   logic [8:0]  fetch_x_s;
   logic        de1_r, hs1_r, vs1_r, img1_r, de2_r, hs2_r, vs2_r, img2_r;
   logic [14:0] pix1_r, pix2_r;
   logic        dim_s;
   logic [7:0]  full_r_s, full_g_s, full_b_s, r_s, g_s, b_s;

   // Raster decode of the current counter position, plus the +2 fetch lookahead
   always_comb begin
      hpos_s       = {1'b0, hcount_r};
      look_s       = hpos_s + 11'd2;
      active_s     = (hcount_r < H_ACT) && (vcount_r < V_ACT);
      hs_s         = (hcount_r >= HS_START) && (hcount_r < HS_END);
      vs_s         = (vcount_r >= VS_START) && (vcount_r < VS_END);
      in_img_s     = (hpos_s >= IMG_LO) && (hpos_s < IMG_HI);
      fetch_s      = (look_s >= IMG_LO) && (look_s < IMG_HI);
      fetch_x_s    = fetch_s ? 9'(look_s - IMG_LO) : 9'd0;
      line_start_s = (hcount_r == 10'd0) && !vcount_r[0];
   end

   // Free-running pixel and line counters; reset parks on the last line so a frame sync follows release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcount_r <= 10'd0;
         vcount_r <= V_LAST;
      end else if (hcount_r == H_LAST) begin
         hcount_r <= 10'd0;
         vcount_r <= (vcount_r == V_LAST) ? 10'd0 : vcount_r + 10'd1;
      end else begin
         hcount_r <= hcount_r + 10'd1;
      end
   end

   // Hq2x control: line/frame pulses and read address
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_x      <= 10'd0;
         reset_line  <= 1'b0;
         reset_frame <= 1'b0;
      end else begin
         read_x      <= {vcount_r[0], fetch_x_s};
         reset_line  <= line_start_s;
         reset_frame <= line_start_s && (vcount_r == V_LAST);
      end
   end

   // Two-stage delay of raster flags and fetched pixel; outpixel already lines up with the counter here
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de1_r  <= 1'b0;  hs1_r <= 1'b0;  vs1_r <= 1'b0;  img1_r <= 1'b0;
         de2_r  <= 1'b0;  hs2_r <= 1'b0;  vs2_r <= 1'b0;  img2_r <= 1'b0;
         pix1_r <= 15'd0;
         pix2_r <= 15'd0;
      end else begin
         de1_r  <= active_s;  hs1_r <= hs_s;   vs1_r <= vs_s;   img1_r <= in_img_s;
         de2_r  <= de1_r;     hs2_r <= hs1_r;  vs2_r <= vs1_r;  img2_r <= img1_r;
         pix1_r <= outpixel;
         pix2_r <= pix1_r;
      end
   end

`ifdef HQ2X_SCANLINE_EN
   logic odd1_r, odd2_r;

   // Line parity follows the same delay as the colour data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         odd1_r <= 1'b0;
         odd2_r <= 1'b0;
      end else begin
         odd1_r <= vcount_r[0];
         odd2_r <= odd1_r;
      end
   end

   assign dim_s = scanlines && odd2_r;
`else
   assign dim_s = 1'b0;
`endif

   // Colour expansion, blanking outside the image and optional scanline dimming
   always_comb begin
      full_r_s = expand5(pix2_r[4:0]);
      full_g_s = expand5(pix2_r[9:5]);
      full_b_s = expand5(pix2_r[14:10]);
      if (de2_r && img2_r) begin
         r_s = dim_s ? {1'b0, full_r_s[7:1]} : full_r_s;
         g_s = dim_s ? {1'b0, full_g_s[7:1]} : full_g_s;
         b_s = dim_s ? {1'b0, full_b_s[7:1]} : full_b_s;
      end else begin
         r_s = 8'd0;
         g_s = 8'd0;
         b_s = 8'd0;
      end
   end

   // Registered video outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de    <= 1'b0;
         hsync <= SYNC_NEG;
         vsync <= SYNC_NEG;
         r     <= 8'd0;
         g     <= 8'd0;
         b     <= 8'd0;
      end else begin
         de    <= de2_r;
         hsync <= hs2_r ^ SYNC_NEG;
         vsync <= vs2_r ^ SYNC_NEG;
         r     <= r_s;
         g     <= g_s;
         b     <= b_s;
      end
   end

endmodule

// File: tb/tb_hq2x_scanout.sv
// Bench for hq2x_scanout with a shortened vertical frame (27 lines) so two frames stay short.
// A raster model derived from position arithmetic is checked every cycle, plus literal spot checks.
module tb_hq2x_scanout;

   localparam int HT  = 800;
   localparam int VA  = 20;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int MID   = 2 * FRAME + 10 * HT + 300;

   logic        clk;
   logic        reset_n;
   logic [14:0] outpixel;
   logic [9:0]  read_x;
   logic        reset_line, reset_frame, hsync, vsync, de;
   logic [7:0]  r, g, b;
`ifdef HQ2X_SCANLINE_EN
   logic        scan;
`endif

   int checks = 0;
   int errors = 0;
   int n;
   int sel;
   bit started;

   hq2x_scanout #(
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .outpixel(outpixel),
`ifdef HQ2X_SCANLINE_EN
      .scanlines(scan),
`endif
      .read_x(read_x),
      .reset_line(reset_line),
      .reset_frame(reset_frame),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .r(r),
      .g(g),
      .b(b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] const_pix(input int s);
      case (s)
         1: return 15'h7FFF;
         2: return 15'h0421;
         3: return 15'h001F;
         default: return 15'h0000;
      endcase
   endfunction

   function automatic int stim_for_line(input int ln);
      case (ln)
         8, 12, 13: return 1;
         9: return 2;
         10: return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int line_of(input int pos);
      return (VT - 1 + pos / HT) % VT;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d actual=%0h required=%0h", nm, n, act, exp);
      end
   endtask

   // Clock count since reset release: cycle index n during which outputs are observed
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) n <= 0;
      else n <= n + 1;
   end

   // Hq2x output buffer model: registered read data, pattern x or a constant colour
   always @(posedge clk) begin
      outpixel <= (sel == 0) ? {6'd0, read_x[8:0]} : const_pix(sel);
   end

   int cp, chc, cln, cq, qhc, qln, h2;
   logic [14:0] cpx;
   logic [7:0]  er, eg, eb;
   logic        ed, ehs, evs, erl, erf;
   logic [9:0]  erx;

   // Per-cycle comparison against the raster model (outputs trail the counters by 3 clocks)
   always @(negedge clk) begin
      #1;
      if (started) begin
         if (!reset_n) begin
            chk("rst_de", de, 0);        chk("rst_hsync", hsync, 1);  chk("rst_vsync", vsync, 1);
            chk("rst_rgb", {r, g, b}, 0); chk("rst_read_x", read_x, 0);
            chk("rst_line", reset_line, 0); chk("rst_frame", reset_frame, 0);
         end else begin
            cp = n - 3;
            ed = 1'b0; ehs = 1'b1; evs = 1'b1; er = 8'd0; eg = 8'd0; eb = 8'd0;
            if (cp >= 0) begin
               chc = cp % HT;
               cln = line_of(cp);
               ed  = (chc < 640) && (cln < VA);
               ehs = !((chc >= 656) && (chc < 752));
               evs = !((cln >= VA + VFP) && (cln < VA + VFP + VS));
               if (ed && chc >= 64 && chc < 576) begin
                  cpx = (sel == 0) ? 15'(chc - 64) : const_pix(sel);
                  er = {cpx[4:0], cpx[4:2]};
                  eg = {cpx[9:5], cpx[9:7]};
                  eb = {cpx[14:10], cpx[14:12]};
`ifdef HQ2X_SCANLINE_EN
                  if (scan && (cln % 2 == 1)) begin
                     er = er >> 1; eg = eg >> 1; eb = eb >> 1;
                  end
`endif
               end
            end
            cq = n - 1;
            erl = 1'b0; erf = 1'b0; erx = 10'd0;
            if (cq >= 0) begin
               qhc = cq % HT;
               qln = line_of(cq);
               erl = (qhc == 0) && (qln % 2 == 0);
               erf = erl && (qln == VT - 1);
               h2  = qhc + 2;
               erx[9]   = (qln % 2 == 1);
               erx[8:0] = (h2 >= 64 && h2 < 576) ? 9'(h2 - 64) : 9'd0;
            end
            chk("de", de, ed);         chk("hsync", hsync, ehs);   chk("vsync", vsync, evs);
            chk("r", r, er);           chk("g", g, eg);            chk("b", b, eb);
            chk("read_x", read_x, erx);
            chk("reset_line", reset_line, erl);
            chk("reset_frame", reset_frame, erf);
         end
      end
   end

   int rl_cnt = 0, rf_cnt = 0, de_cnt = 0, hs_lo = 0, vs_lo = 0;

   initial begin
      reset_n = 1'b1;
      sel = 0;
      started = 1'b0;
`ifdef HQ2X_SCANLINE_EN
      scan = 1'b1;
`endif
      #1 reset_n = 1'b0;
      started = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      for (int k = 0; k < MID + 10; k++) begin
         @(negedge clk);
         if (n % HT == 700) sel = stim_for_line((line_of(n) + 1) % VT);
`ifdef HQ2X_SCANLINE_EN
         if (n == FRAME + 700) scan = 1'b0;
`endif
         if (n >= 1 && n < 1 + FRAME) begin
            rl_cnt += int'(reset_line);
            rf_cnt += int'(reset_frame);
         end
         if (n >= 3 && n < 3 + FRAME) begin
            de_cnt += int'(de);
            hs_lo  += int'(!hsync);
            vs_lo  += int'(!vsync);
         end
         case (n)
            1:    begin chk("lit_first_line", reset_line, 1); chk("lit_first_frame", reset_frame, 1); end
            2:    chk("lit_line_pulse_end", reset_line, 0);
            866:  begin chk("lit_col63_de", de, 1); chk("lit_col63_rgb", {r, g, b}, 24'h000000); end
            867:  begin chk("lit_col64_de", de, 1); chk("lit_col64_rgb", {r, g, b}, 24'h000000); end
            868:  chk("lit_col65_r", r, 8'h08);
            1378: chk("lit_col575_rgb", {r, g, b}, 24'hFF7B00);
            1379: begin chk("lit_col576_de", de, 1); chk("lit_col576_rgb", {r, g, b}, 24'h000000); end
            1458: chk("lit_hsync_pre", hsync, 1);
            1459: chk("lit_hsync_start", hsync, 0);
            1554: chk("lit_hsync_last", hsync, 0);
            1555: chk("lit_hsync_end", hsync, 1);
            7303: chk("lit_7fff", {r, g, b}, 24'hFFFFFF);
            8103: chk("lit_0421", {r, g, b}, 24'h080808);
            8903: chk("lit_001f", {r, g, b}, 24'hFF0000);
            10503: chk("lit_even_line", {r, g, b}, 24'hFFFFFF);
`ifdef HQ2X_SCANLINE_EN
            11303: chk("lit_odd_line_dim", {r, g, b}, 24'h7F7F7F);
`else
            11303: chk("lit_odd_line", {r, g, b}, 24'hFFFFFF);
`endif
            32903: chk("lit_odd_line_frame2", {r, g, b}, 24'hFFFFFF);
            default: ;
         endcase
         if (n == MID) begin
            reset_n = 1'b0;
            #1;
            chk("async_de", de, 0);          chk("async_rgb", {r, g, b}, 0);
            chk("async_hsync", hsync, 1);    chk("async_vsync", vsync, 1);
            chk("async_read_x", read_x, 0);  chk("async_line", reset_line, 0);
            repeat (5) @(negedge clk);
            reset_n = 1'b1;
            break;
         end
      end

      chk("cnt_reset_line", rl_cnt, 14);
      chk("cnt_reset_frame", rf_cnt, 1);
      chk("cnt_de", de_cnt, 640 * VA);
      chk("cnt_hsync_low", hs_lo, 96 * VT);
      chk("cnt_vsync_low", vs_lo, HT * VS);

      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("lit_rst_line", reset_line, 1);
            chk("lit_rst_frame", reset_frame, 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
